// File: rtl/imm_operand_encoder_pkg.sv
// Purpose : shared types, widths and rotate helper for the immediate operand encoder.
// Latency : n/a (declarations only).
// Backpres: n/a.
// Contents: FSM state encoding, field widths, rol32(value, amt5) shared with the Val2 generator.
package imm_operand_encoder_pkg;

  localparam int ROT_W           = 4;
  localparam int IMM8_W          = 8;
  localparam int SHIFT_OPERAND_W = 12;
  localparam int NUM_ROT         = 16;

  localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
  localparam logic [1:0] ST_SEARCH_ENC = 2'd1;
  localparam logic [1:0] ST_DONE_ENC   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = ST_IDLE_ENC,
    ST_SEARCH = ST_SEARCH_ENC,
    ST_DONE   = ST_DONE_ENC
  } state_e;

  // True 32-bit rotate left. A right shift by 32 yields zero, so amt5=0
  // degenerates cleanly to the identity.
  function automatic logic [31:0] rol32(input logic [31:0] value, input logic [4:0] amt5);
    logic [5:0] rsh;
    rsh = 6'd32 - {1'b0, amt5};
    return (value << amt5) | (value >> rsh);
  endfunction

endpackage

// File: rtl/imm_operand_encoder_rot_check.sv
// Purpose : tests one rotation candidate k: hit when ROL(value, 2k) fits in 8 bits.
// Latency : combinational.
// Backpres: none.
// Ports   : value_i (32b), k_i (rotate_imm) in; hit_o, imm8_o out.
module imm_rot_check
  import imm_operand_encoder_pkg::*;
(
  input  logic [31:0]       value_i,
  input  logic [ROT_W-1:0]  k_i,
  output logic              hit_o,
  output logic [IMM8_W-1:0] imm8_o
);

  logic [31:0] rotated;

  // Rotating left by 2k undoes the architectural ROR(imm8, 2k).
  assign rotated = rol32(value_i, {k_i, 1'b0});
  assign hit_o   = (rotated[31:IMM8_W] == '0);
  assign imm8_o  = rotated[IMM8_W-1:0];

endmodule

// File: rtl/imm_operand_encoder.sv
// Purpose : searches rotations for an ARM {rotate_imm, imm8} encoding of a 32-bit constant.
// Latency : floor(k/ROT_PER_CYCLE)+1 cycles on a hit at k, 16/ROT_PER_CYCLE on a miss.
// Backpres: one request at a time; result held in DONE until out_ready, in_ready only in IDLE.
// Ports   : clk, rst (sync, active-high); in_valid/in_ready/in_value request;
//           out_valid/out_ready/out_found/out_shift_operand result.
// Option  : IMM_ENC_INVERT_EN also searches ~value and adds out_inverted.
module imm_operand_encoder
  import imm_operand_encoder_pkg::*;
#(
  parameter int ROT_PER_CYCLE = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_value,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_found,
  output logic [SHIFT_OPERAND_W-1:0] out_shift_operand
`ifdef IMM_ENC_INVERT_EN
  ,
  output logic                       out_inverted
`endif
);

  localparam logic [ROT_W-1:0] ROT_STEP = ROT_W'(ROT_PER_CYCLE);
  localparam logic [ROT_W-1:0] ROT_LAST = ROT_W'(NUM_ROT - ROT_PER_CYCLE);

  state_e                     state_q;
  logic [ROT_W-1:0]           rot_q;
  logic [31:0]                value_q;
  logic                       in_ready_q;
  logic                       out_valid_q;
  logic                       found_q;
  logic [SHIFT_OPERAND_W-1:0] shift_op_q;

  logic [ROT_PER_CYCLE-1:0]   dir_hit;
  logic [IMM8_W-1:0]          dir_imm [ROT_PER_CYCLE];
  logic [ROT_W-1:0]           lane_k  [ROT_PER_CYCLE];

  logic                       hit_any;
  logic [ROT_W-1:0]           hit_k;
  logic [IMM8_W-1:0]          hit_imm;
  logic                       last_blk;

`ifdef IMM_ENC_INVERT_EN
  logic [ROT_PER_CYCLE-1:0]   inv_hit;
  logic [IMM8_W-1:0]          inv_imm [ROT_PER_CYCLE];
  logic                       hit_inv;
  logic                       inverted_q;
`endif

  // rot_q is always a multiple of ROT_PER_CYCLE, so lane k never wraps past 15.
  for (genvar g = 0; g < ROT_PER_CYCLE; g++) begin : g_lane
    assign lane_k[g] = rot_q + ROT_W'(g);

    imm_rot_check u_dir (
      .value_i (value_q),
      .k_i     (lane_k[g]),
      .hit_o   (dir_hit[g]),
      .imm8_o  (dir_imm[g])
    );

`ifdef IMM_ENC_INVERT_EN
    imm_rot_check u_inv (
      .value_i (~value_q),
      .k_i     (lane_k[g]),
      .hit_o   (inv_hit[g]),
      .imm8_o  (inv_imm[g])
    );
`endif
  end

  // Walk lanes high to low so the lowest k overwrites; within a lane the
  // direct check comes last so it beats the inverted one.
  always_comb begin
    hit_any = 1'b0;
    hit_k   = '0;
    hit_imm = '0;
`ifdef IMM_ENC_INVERT_EN
    hit_inv = 1'b0;
`endif
    for (int i = ROT_PER_CYCLE - 1; i >= 0; i--) begin
`ifdef IMM_ENC_INVERT_EN
      if (inv_hit[i]) begin
        hit_any = 1'b1;
        hit_k   = lane_k[i];
        hit_imm = inv_imm[i];
        hit_inv = 1'b1;
      end
`endif
      if (dir_hit[i]) begin
        hit_any = 1'b1;
        hit_k   = lane_k[i];
        hit_imm = dir_imm[i];
`ifdef IMM_ENC_INVERT_EN
        hit_inv = 1'b0;
`endif
      end
    end
  end

  assign last_blk = (rot_q == ROT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rot_q       <= '0;
      value_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      found_q     <= 1'b0;
      shift_op_q  <= '0;
`ifdef IMM_ENC_INVERT_EN
      inverted_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid && in_ready_q) begin
            value_q    <= in_value;
            rot_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ST_SEARCH;
          end
        end
        ST_SEARCH: begin
          if (hit_any) begin
            found_q     <= 1'b1;
            shift_op_q  <= {hit_k, hit_imm};
`ifdef IMM_ENC_INVERT_EN
            inverted_q  <= hit_inv;
`endif
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else if (last_blk) begin
            found_q     <= 1'b0;
            shift_op_q  <= '0;
`ifdef IMM_ENC_INVERT_EN
            inverted_q  <= 1'b0;
`endif
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            rot_q <= rot_q + ROT_STEP;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready          = in_ready_q;
  assign out_valid         = out_valid_q;
  assign out_found         = found_q;
  assign out_shift_operand = shift_op_q;
`ifdef IMM_ENC_INVERT_EN
  assign out_inverted      = inverted_q;
`endif

endmodule

// File: tb/tb_imm_operand_encoder.sv
// Purpose : scoreboard bench for imm_operand_encoder (ROT_PER_CYCLE=1 and 4 instances).
// Latency : latency is measured from the accept edge to first out_valid.
// Backpres: drives out_ready low on one transaction to hold the result in DONE.
module tb_imm_operand_encoder;

  typedef struct {
    logic [31:0] value;
    logic        found;
    logic [11:0] so;
    logic        inv;
    int          lat;
    int          acc;
  } exp_t;

`ifdef IMM_ENC_INVERT_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, out_found, out_inv;
  logic [31:0] in_value = '0;
  logic [11:0] out_so;
  logic        in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b1, out_found4, out_inv4;
  logic [31:0] in_value4 = '0;
  logic [11:0] out_so4;

  exp_t q1[$];
  exp_t q4[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic pv1 = 1'b0, pv4 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  imm_operand_encoder #(.ROT_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_found(out_found), .out_shift_operand(out_so)
`ifdef IMM_ENC_INVERT_EN
    , .out_inverted(out_inv)
`endif
  );

  imm_operand_encoder #(.ROT_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_value(in_value4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .out_found(out_found4), .out_shift_operand(out_so4)
`ifdef IMM_ENC_INVERT_EN
    , .out_inverted(out_inv4)
`endif
  );

`ifndef IMM_ENC_INVERT_EN
  assign out_inv  = 1'b0;
  assign out_inv4 = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] tb_rol(input logic [31:0] v, input int n);
    logic [63:0] d;
    d = {v, v} << n;
    return d[63:32];
  endfunction

  function automatic logic [31:0] tb_ror(input logic [31:0] v, input int n);
    logic [63:0] d;
    d = {v, v} >> n;
    return d[31:0];
  endfunction

  // Reference: lowest k whose left-rotation fits in 8 bits; direct before inverted.
  task automatic model(input logic [31:0] v, input int rpc, output exp_t e);
    logic [31:0] r, ri;
    e.value = v; e.found = 1'b0; e.so = '0; e.inv = 1'b0; e.lat = 16 / rpc; e.acc = 0;
    for (int k = 0; k < 16; k++) begin
      if (!e.found) begin
        r  = tb_rol(v, 2 * k);
        ri = tb_rol(~v, 2 * k);
        if (r[31:8] == 24'd0) begin
          e.found = 1'b1; e.so = {4'(k), r[7:0]}; e.inv = 1'b0; e.lat = k / rpc + 1;
        end else if (INV_EN && ri[31:8] == 24'd0) begin
          e.found = 1'b1; e.so = {4'(k), ri[7:0]}; e.inv = 1'b1; e.lat = k / rpc + 1;
        end
      end
    end
  endtask

  task automatic issue(input int dut, input exp_t e_in, input bit push);
    exp_t e;
    int   t;
    e = e_in;
    t = 0;
    while (((dut == 1) ? !in_ready : !in_ready4) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if ((dut == 1) ? !in_ready : !in_ready4) begin
      check($sformatf("accept_timeout dut%0d", dut), 32'(0), 32'(1));
      return;
    end
    if (dut == 1) begin in_value = e.value; in_valid = 1'b1; end
    else          begin in_value4 = e.value; in_valid4 = 1'b1; end
    @(posedge clk);
    #1;
    // Scribble the input afterwards: the latched value must be unaffected.
    if (dut == 1) begin in_valid = 1'b0; in_value = 32'hDEADBEEF; end
    else          begin in_valid4 = 1'b0; in_value4 = 32'hDEADBEEF; end
    e.acc = cyc;
    if (push) begin
      if (dut == 1) q1.push_back(e);
      else          q4.push_back(e);
    end
  endtask

  task automatic dir1(input logic [31:0] v, input logic f, input logic [11:0] so,
                      input logic inv, input int lat);
    exp_t e;
    e.value = v; e.found = f; e.so = so; e.inv = inv; e.lat = lat; e.acc = 0;
    issue(1, e, 1'b1);
  endtask

  task automatic drain(input int dut);
    int t;
    t = 0;
    while (((dut == 1) ? (q1.size() != 0 || !in_ready) : (q4.size() != 0 || !in_ready4)) && t < 300) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("drain dut%0d", dut),
          32'((dut == 1) ? (q1.size() == 0 && in_ready) : (q4.size() == 0 && in_ready4)), 32'(1));
  endtask

  always @(negedge clk) begin : mon1
    exp_t e;
    if (!rst && out_valid && !pv1) begin
      if (q1.size() == 0) begin
        check("dut1 unexpected_result", 32'(out_valid), 32'(0));
      end else begin
        e = q1.pop_front();
        check($sformatf("dut1 %h found", e.value), 32'(out_found), 32'(e.found));
        check($sformatf("dut1 %h shift_operand", e.value), 32'(out_so), 32'(e.so));
        check($sformatf("dut1 %h inverted", e.value), 32'(out_inv), 32'(e.inv));
        check($sformatf("dut1 %h latency", e.value), 32'(cyc - e.acc), 32'(e.lat));
      end
    end
    pv1 = out_valid;
  end

  always @(negedge clk) begin : mon4
    exp_t e;
    if (!rst && out_valid4 && !pv4) begin
      if (q4.size() == 0) begin
        check("dut4 unexpected_result", 32'(out_valid4), 32'(0));
      end else begin
        e = q4.pop_front();
        check($sformatf("dut4 %h found", e.value), 32'(out_found4), 32'(e.found));
        check($sformatf("dut4 %h shift_operand", e.value), 32'(out_so4), 32'(e.so));
        check($sformatf("dut4 %h inverted", e.value), 32'(out_inv4), 32'(e.inv));
        check($sformatf("dut4 %h latency", e.value), 32'(cyc - e.acc), 32'(e.lat));
        if (out_found4)
          check($sformatf("dut4 %h roundtrip", e.value),
                tb_ror({24'd0, out_so4[7:0]}, int'(out_so4[11:8]) * 2) ^ {32{out_inv4}}, e.value);
      end
    end
    pv4 = out_valid4;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    exp_t        e;
    int          t;
    logic [31:0] v;
    logic [31:0] fixed4 [7];

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset in_ready", 32'(in_ready), 32'(1));
    check("reset out_valid", 32'(out_valid), 32'(0));
    check("reset out_found", 32'(out_found), 32'(0));
    check("reset shift_operand", 32'(out_so), 32'(0));
    check("reset inverted", 32'(out_inv), 32'(0));
    rst = 1'b0;

    // Directed vectors, ROT_PER_CYCLE=1
    dir1(32'h000000FF, 1'b1, 12'h0FF, 1'b0, 1);
    dir1(32'hFF000000, 1'b1, 12'h4FF, 1'b0, 5);
    dir1(32'hF000000F, 1'b1, 12'h2FF, 1'b0, 3);
    dir1(32'h00000104, 1'b1, 12'hF41, 1'b0, 16);
    dir1(32'h00000101, 1'b0, 12'h000, 1'b0, 16);
    dir1(32'h00000000, 1'b1, 12'h000, 1'b0, 1);
`ifdef IMM_ENC_INVERT_EN
    dir1(32'hFFFFFF00, 1'b1, 12'h0FF, 1'b1, 1);
`else
    dir1(32'hFFFFFF00, 1'b0, 12'h000, 1'b0, 16);
`endif
    drain(1);

    // Backpressure: hold the result for 10 cycles, poke in_valid meanwhile
    out_ready = 1'b0;
    dir1(32'h000003FC, 1'b1, 12'hFFF, 1'b0, 16);
    t = 0;
    while (!out_valid && t < 50) begin @(negedge clk); t++; end
    check("bp out_valid_arrives", 32'(out_valid), 32'(1));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = i[0];
      in_value = 32'h00000000;
      check("bp out_valid_held", 32'(out_valid), 32'(1));
      check("bp found_held", 32'(out_found), 32'(1));
      check("bp shift_operand_held", 32'(out_so), 32'(12'hFFF));
      check("bp in_ready_low", 32'(in_ready), 32'(0));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp release in_ready", 32'(in_ready), 32'(1));
    check("bp release out_valid", 32'(out_valid), 32'(0));
    drain(1);

    // Reset in the middle of a miss search; the result must never appear
    e.value = 32'h00000101; e.found = 1'b0; e.so = '0; e.inv = 1'b0; e.lat = 16; e.acc = 0;
    issue(1, e, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midreset out_valid", 32'(out_valid), 32'(0));
    check("midreset in_ready", 32'(in_ready), 32'(1));
    dir1(32'h00000000, 1'b1, 12'h000, 1'b0, 1);
    drain(1);

    // ROT_PER_CYCLE=4 instance against the reference model
    fixed4[0] = 32'h00000000; fixed4[1] = 32'hFFFFFFFF; fixed4[2] = 32'h00000101;
    fixed4[3] = 32'h00000104; fixed4[4] = 32'hFF000000; fixed4[5] = 32'hFFFFFF00;
    fixed4[6] = 32'h0003FC00;
    for (int i = 0; i < 7; i++) begin
      model(fixed4[i], 4, e);
      issue(4, e, 1'b1);
    end
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) v = tb_ror(32'($urandom_range(0, 255)), 2 * int'($urandom_range(0, 15)));
      else            v = $urandom;
      model(v, 4, e);
      issue(4, e, 1'b1);
    end
    drain(4);

    check("q1 empty", 32'(q1.size()), 32'(0));
    check("q4 empty", 32'(q4.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
